prediction_history: RTL and testbench

//  Parametrised successor to the single-entry predicted-digit store and its one-command reader.
//  - Keeps a circular log of the last DEPTH inference results.
//  - Serves a four-command UART query protocol: latest, count, dump, clear.
//  - Sits between inference (inference_done edge -> wr_en) and the shared uart_rx/uart_tx pair.

---
 rtl/prediction_history.sv | 191 +++++++++++++++++++
 tb/tb_prediction_history.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prediction_history.sv
// Circular log of recent inference results with a four-command UART query
// front end (latest, count, dump, clear).
module prediction_history #(
    parameter int         DEPTH      = 16,
    parameter int         DIGIT_W    = 4,
    parameter logic [7:0] CMD_LATEST = 8'hCC,
    parameter logic [7:0] CMD_COUNT  = 8'hCD,
    parameter logic [7:0] CMD_DUMP   = 8'hCE,
    parameter logic [7:0] CMD_CLEAR  = 8'hCF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DIGIT_W-1:0]       wr_digit,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_send,
    input  logic                     tx_busy,
    output logic [DIGIT_W-1:0]       latest_digit,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              total_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FETCH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DIGIT_W-1:0] mem [DEPTH];
    logic [DIGIT_W-1:0] rd_data;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_idx;
    logic [CW-1:0]      n_bytes;
    logic [7:0]         cmd;
    logic [7:0]         hdr;
    logic [7:0]         hdr_nx;
    logic [7:0]         count_byte;
    logic               first;
    logic               known;
    logic               clr;
    logic               is_dump;

    assign known = (rx_data == CMD_LATEST) || (rx_data == CMD_COUNT) ||
                   (rx_data == CMD_DUMP)   || (rx_data == CMD_CLEAR);
    assign is_dump = (cmd == CMD_DUMP);
    assign clr     = (state == S_LOAD) && (cmd == CMD_CLEAR);

    always_comb begin
        count_byte = 8'(count);
        if (32'(count) > 32'd255) begin
            count_byte = 8'hFF;
        end
    end

    always_comb begin
        hdr_nx = 8'h00;
        unique case (1'b1)
            cmd == CMD_LATEST:
                hdr_nx = (count == '0) ? 8'hFF : 8'(latest_digit);
            cmd == CMD_COUNT:  hdr_nx = count_byte;
            cmd == CMD_DUMP:   hdr_nx = count_byte;
            cmd == CMD_CLEAR:  hdr_nx = 8'hAA;
            default:           hdr_nx = 8'h00;
        endcase
    end

    // Log storage; the bypass keeps dump reads live against a same-cycle write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_digit;
        end
        if (wr_en && (wr_ptr == rd_idx)) begin
            rd_data <= wr_digit;
        end else begin
            rd_data <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            count        <= '0;
            total_count  <= '0;
            latest_digit <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (clr) begin
                count        <= wr_en ? CW'(1) : '0;
                total_count  <= wr_en ? 16'd1 : 16'd0;
                latest_digit <= wr_en ? wr_digit : '0;
            end else if (wr_en) begin
                latest_digit <= wr_digit;
                if (count != CW'(DEPTH)) begin
                    count <= count + CW'(1);
                end
                if (total_count != 16'hFFFF) begin
                    total_count <= total_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd     <= '0;
            hdr     <= '0;
            n_bytes <= '0;
            rd_idx  <= '0;
            first   <= 1'b0;
        end else begin
            if ((state == S_IDLE) && rx_ready && known) begin
                cmd <= rx_data;
            end
            if (state == S_LOAD) begin
                hdr     <= hdr_nx;
                first   <= 1'b1;
                n_bytes <= is_dump ? (count + CW'(1)) : CW'(1);
                // One slot before the oldest: the header byte advances it.
                rd_idx  <= wr_ptr - AW'(count) - AW'(1);
            end
            if ((state == S_WAIT_DONE) && !tx_busy) begin
                n_bytes <= n_bytes - CW'(1);
                rd_idx  <= rd_idx + AW'(1);
                first   <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        tx_send  = 1'b0;
        tx_data  = 8'h00;
        busy     = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (rx_ready && known) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nx = S_SEND;
            end
            S_SEND: begin
                tx_data = first ? hdr : 8'(rd_data);
                if (!tx_busy) begin
                    tx_send  = 1'b1;
                    state_nx = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_nx = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx = (n_bytes == CW'(1)) ? S_IDLE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_nx = S_SEND;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prediction_history.sv
// Scoreboard bench for prediction_history: expected reply bytes are queued
// when a command is issued and popped as the DUT transmits.
module tb_prediction_history;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_digit;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic [3:0]  latest_digit;
    logic [4:0]  count;
    logic [15:0] total_count;
    logic        busy;

    logic uart_busy;
    logic hold_busy;
    assign tx_busy = uart_busy | hold_busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pulse = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    prediction_history dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_digit     (wr_digit),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_busy      (tx_busy),
        .latest_digit (latest_digit),
        .count        (count),
        .total_count  (total_count),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic write(input logic [3:0] d);
        wr_en    = 1'b1;
        wr_digit = d;
        @(posedge clk); #1;
        wr_en    = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (!busy && !tx_busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        #1;
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_pulse();
        int p0 = n_pulse;
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (n_pulse != p0) begin
                ok = 1;
                break;
            end
        end
        #1;
        chk("pulse_timeout", 32'(ok), 32'd1);
    endtask

    // UART model: each transmit request keeps the line busy for a few cycles.
    initial begin
        logic [7:0] e;
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1) begin
                n_pulse++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(e));
                end
                @(posedge clk); #1;
                uart_busy = 1'b1;
                @(negedge clk);
                chk("pulse_width", 32'(tx_send), 32'd0);
                repeat (3) @(posedge clk);
                #1;
                uart_busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b0; wr_en = 1'b0; wr_digit = '0;
        rx_data = '0; rx_ready = 1'b0; hold_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx_send", 32'(tx_send), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_total", 32'(total_count), 32'd0);
        chk("rst_latest", 32'(latest_digit), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        exp_q.push_back(8'hFF);
        send_cmd(8'hCC);
        wait_idle();
        exp_q.push_back(8'h00);
        send_cmd(8'hCD);
        wait_idle();
        send_cmd(8'h55);
        repeat (3) @(posedge clk);
        #1;
        chk("unknown_ignored", 32'(busy), 32'd0);

        write(4'd3); write(4'd7); write(4'd1);
        chk("latest_371", 32'(latest_digit), 32'd1);
        chk("total_371", 32'(total_count), 32'd3);
        chk("count_371", 32'(count), 32'd3);
        exp_q.push_back(8'h03); exp_q.push_back(8'h03);
        exp_q.push_back(8'h07); exp_q.push_back(8'h01);
        send_cmd(8'hCE);
        wait_idle();

        exp_q.push_back(8'hAA);
        send_cmd(8'hCF);
        wait_idle();
        chk("count_clr", 32'(count), 32'd0);
        for (int i = 0; i < 20; i++) write(4'(i % 10));
        chk("count_full", 32'(count), 32'd16);
        chk("total_20", 32'(total_count), 32'd20);
        exp_q.push_back(8'h10);
        for (int i = 4; i < 20; i++) exp_q.push_back(8'(i % 10));
        send_cmd(8'hCE);
        wait_idle();

        // Clear and write land in the same cycle.
        exp_q.push_back(8'hAA);
        send_cmd(8'hCF);
        write(4'd5);
        wait_idle();
        chk("clrwr_count", 32'(count), 32'd1);
        chk("clrwr_latest", 32'(latest_digit), 32'd5);
        chk("clrwr_total", 32'(total_count), 32'd1);

        write(4'd2); write(4'd4);
        hold_busy = 1'b1;
        exp_q.push_back(8'h03); exp_q.push_back(8'h05);
        exp_q.push_back(8'h02); exp_q.push_back(8'h04);
        send_cmd(8'hCE);
        p0 = n_pulse;
        repeat (50) @(posedge clk);
        #1;
        chk("hold_quiet", 32'(n_pulse - p0), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        hold_busy = 1'b0;
        wait_pulse();
        send_cmd(8'hCD);
        wait_idle();

        exp_q.push_back(8'h03); exp_q.push_back(8'h05);
        exp_q.push_back(8'h02); exp_q.push_back(8'h04);
        send_cmd(8'hCE);
        wait_pulse();
        rst = 1'b0;
        #1;
        chk("midrst_tx_send", 32'(tx_send), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(8'hFF);
        send_cmd(8'hCC);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
